// File: rtl/onewire_slave_tx.sv
// onewire_slave_tx
// Slave-side 1-wire byte transmitter. A byte from the command layer is shifted
// out LSB-first, one bit per master read slot. A '0' bit pulls DQ low for
// T_HOLD cycles starting the cycle after the master's falling edge. A '1' bit
// leaves DQ released. A master reset pulse (T_RSTDET consecutive low cycles
// not caused by this block) aborts the byte in flight.
//
// Ports:
//   clk       core clock
//   rst       synchronous active-high reset
//   dq_in     DQ bus level, already synchronized to clk
//   tx_data   byte to send, bit 0 first
//   tx_valid  tx_data valid
//   tx_ready  block can accept a byte (idle)
//   dq_oe     registered open-drain enable, 1 = pull DQ low
//   busy      byte transfer in progress
//   tx_done   one-cycle pulse when all 8 bits have been sent
//   tx_abort  one-cycle pulse when a reset pulse killed the transfer
module onewire_slave_tx #(
    parameter int T_HOLD   = 30,
    parameter int T_RSTDET = 240,
    parameter int CNT_W    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dq_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dq_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] RSTDET_LAST = CNT_W'(T_RSTDET - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

    state_t           state, state_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             dq_d;
    logic             fall;
    logic             dq_oe_nxt;
    logic [CNT_W-1:0] low_cnt;
    logic             reset_pulse;

    assign fall = dq_d & ~dq_in;

    // Consecutive-low counter value for this cycle: clears on a high bus,
    // otherwise increments and saturates rather than wrapping.
    assign low_cnt = dq_in ? '0
                   : ((timer == TIMER_MAX) ? timer : timer + CNT_W'(1));

    // Timer already holds T_RSTDET-1 previous lows, so this low cycle is
    // the T_RSTDET-th one.
    assign reset_pulse = ~dq_in && (timer >= RSTDET_LAST);

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            timer   <= '0;
            dq_d    <= 1'b1;
            dq_oe   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            timer   <= timer_nxt;
            dq_d    <= dq_in;
            dq_oe   <= dq_oe_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        timer_nxt   = timer;
        tx_done     = 1'b0;
        tx_abort    = 1'b0;

        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (tx_valid) begin
                    shift_nxt   = tx_data;
                    bit_cnt_nxt = '0;
                    state_nxt   = ARMED;
                end
            end

            ARMED: begin
                if (reset_pulse) begin
                    tx_abort    = 1'b1;
                    state_nxt   = IDLE;
                    shift_nxt   = '0;
                    bit_cnt_nxt = '0;
                    timer_nxt   = '0;
                end else if (fall && !shift[0]) begin
                    // Timer becomes the hold counter while driving.
                    timer_nxt = '0;
                    state_nxt = DRIVE;
                end else if (fall) begin
                    timer_nxt = low_cnt;
                    state_nxt = RELEASE;
                end else begin
                    // A bus already low on entry has no edge: just count it.
                    timer_nxt = low_cnt;
                end
            end

            DRIVE: begin
                // Own pull-down is not counted toward reset detection.
                if (timer == HOLD_LAST) begin
                    timer_nxt = '0;
                    state_nxt = RELEASE;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (reset_pulse) begin
                    tx_abort    = 1'b1;
                    state_nxt   = IDLE;
                    shift_nxt   = '0;
                    bit_cnt_nxt = '0;
                    timer_nxt   = '0;
                end else if (dq_in) begin
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    timer_nxt   = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_done   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = ARMED;
                    end
                end else begin
                    timer_nxt = low_cnt;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Registered so the pad enable is glitch-free and strictly tied to DRIVE.
    assign dq_oe_nxt = (state_nxt == DRIVE);

endmodule

// File: tb/tb_onewire_slave_tx.sv
module tb_onewire_slave_tx;

    localparam int T_HOLD   = 30;
    localparam int T_RSTDET = 240;
    localparam int CNT_W    = 9;

    localparam int EV_RISE  = 0;
    localparam int EV_FALL  = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ABORT = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       mst_low  = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       dq_in;
    logic       tx_ready;
    logic       dq_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_abort;

    // Open-drain bus: low if the master or the slave pulls it.
    assign dq_in = ~(mst_low | dq_oe);

    onewire_slave_tx #(
        .T_HOLD   (T_HOLD),
        .T_RSTDET (T_RSTDET),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dq_in    (dq_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .dq_oe    (dq_oe),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_abort (tx_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    bit   chk_rdy  = 1'b0;
    logic prev_oe  = 1'b0;

    // Reference model of the byte in flight
    bit         m_active = 1'b0;
    logic [7:0] m_byte   = 8'h00;
    int         m_idx    = 0;

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon_event(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d required=none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                failures++;
                $display("FAIL event actual kind=%0d cycle=%0d required kind=%0d cycle=%0d",
                         kind, cyc, e.kind, e.at);
            end
        end
    endtask

    // Monitor: every visible output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (chk_rdy) begin
                chk_rdy = 1'b0;
                check("tx_ready_after_end", int'(tx_ready), 1);
            end
            if (dq_oe && !prev_oe) mon_event(EV_RISE);
            if (!dq_oe && prev_oe) mon_event(EV_FALL);
            if (tx_done) begin
                mon_event(EV_DONE);
                chk_rdy = 1'b1;
            end
            if (tx_abort) begin
                mon_event(EV_ABORT);
                chk_rdy = 1'b1;
            end
            prev_oe = dq_oe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready && n < 1000) begin
            tick();
            n++;
        end
        check("load_wait_ready", int'(tx_ready), 1);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
        m_active = 1'b1;
        m_byte   = b;
        m_idx    = 0;
    endtask

    // One master read slot: bus low for low_len cycles from the current cycle,
    // then released so the whole slot lasts slot_len cycles. Expected slave
    // behaviour is derived from the bit position and the low duration.
    task automatic slot(input int low_len, input int slot_len);
        int  f;
        int  comp;
        int  ab;
        bit  b;
        f = cyc;
        if (m_active) begin
            b  = m_byte[m_idx];
            ab = -1;
            if (!b) begin
                push(EV_RISE, f + 1);
                push(EV_FALL, f + T_HOLD + 1);
                // Low cycles seen after the hold window ends count toward reset.
                if (low_len - 1 - T_HOLD >= T_RSTDET) ab = f + T_HOLD + T_RSTDET;
                comp = (f + low_len > f + T_HOLD + 1) ? f + low_len : f + T_HOLD + 1;
            end else begin
                if (low_len >= T_RSTDET) ab = f + T_RSTDET - 1;
                comp = f + low_len;
            end
            if (ab >= 0) begin
                push(EV_ABORT, ab);
                m_active = 1'b0;
            end else begin
                m_idx++;
                if (m_idx == 8) begin
                    push(EV_DONE, comp);
                    m_active = 1'b0;
                end
            end
        end
        mst_low = 1'b1;
        repeat (low_len) tick();
        mst_low = 1'b0;
        repeat (slot_len - low_len) tick();
    endtask

    task automatic send8_fixed();
        for (int i = 0; i < 8; i++) slot(1, 60);
    endtask

    task automatic send8_rand();
        for (int i = 0; i < 8; i++) slot($urandom_range(1, 15), $urandom_range(40, 70));
    endtask

    initial begin
        int f;
        int lows[4];
        int l;

        // Reset state
        repeat (3) tick();
        check("rst_dq_oe", int'(dq_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_done", int'(tx_done), 0);
        check("rst_tx_abort", int'(tx_abort), 0);
        check("rst_tx_ready", int'(tx_ready), 1);
        rst = 1'b0;
        tick();
        prev_oe = dq_oe;
        mon_en  = 1'b1;

        // rst and tx_valid together: byte must not be taken
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        tick();
        rst      = 1'b0;
        tx_valid = 1'b0;
        tick();
        check("rst_wins_busy", int'(busy), 0);
        check("rst_wins_ready", int'(tx_ready), 1);

        // Directed bytes
        load(8'hA5);
        send8_fixed();
        load(8'hFF);
        send8_fixed();
        load(8'h00);
        send8_fixed();

        // Reset pulse in RELEASE after 3 bits of 0x00, then restart with 0x01
        load(8'h00);
        for (int i = 0; i < 3; i++) slot(1, 60);
        slot(T_HOLD + T_RSTDET + 6, T_HOLD + T_RSTDET + 60);
        check("after_abort_ready", int'(tx_ready), 1);
        load(8'h01);
        send8_fixed();

        // Long low already present on entry to ARMED: not a slot, no abort
        mst_low = 1'b1;
        repeat (5) tick();
        load(8'h00);
        repeat (190) tick();
        mst_low = 1'b0;
        repeat (20) tick();
        check("long_low_still_busy", int'(busy), 1);
        send8_fixed();

        // Synchronous reset 10 cycles into a drive window
        load(8'h00);
        f = cyc;
        push(EV_RISE, f + 1);
        push(EV_FALL, f + 11);
        mst_low = 1'b1;
        tick();
        mst_low = 1'b0;
        while (cyc < f + 10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_active = 1'b0;
        check("mid_drive_rst_oe", int'(dq_oe), 0);
        check("mid_drive_rst_ready", int'(tx_ready), 1);
        repeat (40) tick();

        // tx_valid held while busy: ignored until the block is ready again
        load(8'h5A);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick();
        check("held_valid_ready", int'(tx_ready), 0);
        send8_fixed();
        tx_valid = 1'b0;
        m_active = 1'b1;
        m_byte   = 8'h3C;
        m_idx    = 0;
        check("held_valid_accepted", int'(busy), 1);
        send8_fixed();

        // Randomized bytes with occasional long lows around the reset threshold
        lows[0] = T_RSTDET - 1;
        lows[1] = T_RSTDET;
        lows[2] = T_HOLD + T_RSTDET;
        lows[3] = T_HOLD + T_RSTDET + 1;
        for (int n = 0; n < 20; n++) begin
            load(8'($urandom));
            for (int i = 0; i < 8; i++) begin
                if (!m_active) break;
                if ($urandom_range(0, 9) == 0) begin
                    l = lows[$urandom_range(0, 3)];
                    slot(l, l + 45);
                end else begin
                    slot($urandom_range(1, 15), $urandom_range(40, 70));
                end
            end
            repeat ($urandom_range(1, 10)) tick();
        end

        repeat (50) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
